// File: rtl/sys_split_plan_reader.sv
// sys_split_plan_reader: consumer end of the split-plan table. It walks the
// records from plan_last down to 0 so children are seen before the parents that
// merge them. Leaf records become compute commands and merge records become
// combine commands, sent over a valid/ready handshake.
// Optional build macro: SPLIT_READER_CHECK_EN adds per-record sanity checks in
// DECODE that raise err without stopping the walk.
module sys_split_plan_reader #(
  parameter int ARRAY_MAX_W   = 4,
  parameter int ARRAY_MAX_L   = 4,
  parameter int ARRAY_MAX_A_L = 4,
  parameter int OUT_SIZE      = 100
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         plan_ready,
  input  logic [15:0]  plan_last,
  output logic         rd_en,
  output logic [15:0]  rd_addr,
  input  logic [258:0] rd_data,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output logic         cmd_kind,
  output logic [1:0]   cmd_op,
  output logic [15:0]  cmd_idx,
  output logic [15:0]  cmd_src0,
  output logic [15:0]  cmd_src1,
  output logic [15:0]  cmd_m,
  output logic [15:0]  cmd_k,
  output logic [15:0]  cmd_n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  cmd_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_DECODE,
    S_ISSUE,
    S_FIN
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    idx_q, idx_d;
  logic [15:0]    last_q, last_d;
  logic [258:0]   rec_q, rec_d;
  logic           kind_q, kind_d;
  logic [1:0]     op_q, op_d;
  logic [15:0]    cidx_q, cidx_d;
  logic [15:0]    src0_q, src0_d;
  logic [15:0]    src1_q, src1_d;
  logic [15:0]    m_q, m_d;
  logic [15:0]    k_q, k_d;
  logic [15:0]    n_q, n_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           abort_q, abort_d;
  logic [15:0]    count_q, count_d;

  // Fields of the held record used for command generation.
  logic [15:0] f_a_w0, f_a_l0, f_b_w0, f_b_l0, f_o_w0, f_o_l0, f_to_n1, f_to_n2;
  logic [1:0]  f_op;

  assign f_a_w0  = rec_q[242:227];
  assign f_a_l0  = rec_q[226:211];
  assign f_b_w0  = rec_q[178:163];
  assign f_b_l0  = rec_q[162:147];
  assign f_o_w0  = rec_q[114:99];
  assign f_o_l0  = rec_q[98:83];
  assign f_to_n1 = rec_q[50:35];
  assign f_to_n2 = rec_q[34:19];
  assign f_op    = rec_q[1:0];

  logic rec_bad;
  logic unused_rec;

`ifdef SPLIT_READER_CHECK_EN
  // Sanity check of the held record against array limits and table ordering.
  always_comb begin
    rec_bad = 1'b0;
    if (f_op == 2'd0) begin
      rec_bad = (f_b_w0 != f_a_l0)
             || ({16'd0, f_a_w0} > 32'(ARRAY_MAX_W))
             || ({16'd0, f_a_l0} > 32'(ARRAY_MAX_A_L))
             || ({16'd0, f_b_l0} > 32'(ARRAY_MAX_L))
             || (f_a_w0 == '0) || (f_a_l0 == '0)
             || (f_b_w0 == '0) || (f_b_l0 == '0);
    end else begin
      rec_bad = (f_to_n1 > last_q) || (f_to_n2 > last_q)
             || (f_to_n1 <= idx_q) || (f_to_n2 <= idx_q);
    end
  end
  assign unused_rec = ^{rec_q[258:243], rec_q[210:179], rec_q[146:115],
                        rec_q[82:51], rec_q[18:2]};
`else
  assign rec_bad    = 1'b0;
  assign unused_rec = ^{rec_q[258:243], rec_q[210:179], rec_q[178:163],
                        rec_q[146:115], rec_q[82:51], rec_q[18:2], last_q,
                        (ARRAY_MAX_W != 0), (ARRAY_MAX_L != 0),
                        (ARRAY_MAX_A_L != 0)};
`endif

  // State and datapath registers; reset drops any pending command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      rec_q   <= '0;
      kind_q  <= 1'b0;
      op_q    <= '0;
      cidx_q  <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rec_q   <= rec_d;
      kind_q  <= kind_d;
      op_q    <= op_d;
      cidx_q  <= cidx_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      m_q     <= m_d;
      k_q     <= k_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      count_q <= count_d;
    end
  end

  // Next-state logic for the walk: READ -> WAIT -> DECODE -> ISSUE per record.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rec_d   = rec_q;
    kind_d  = kind_q;
    op_d    = op_q;
    cidx_d  = cidx_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    m_d     = m_q;
    k_d     = k_q;
    n_d     = n_q;
    busy_d  = busy_q;
    err_d   = err_q;
    abort_d = abort_q;
    count_d = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && plan_ready) begin
          idx_d   = plan_last;
          last_d  = plan_last;
          busy_d  = 1'b1;
          count_d = '0;
          err_d   = 1'b0;
          abort_d = 1'b0;
          if ({16'd0, plan_last} >= 32'(OUT_SIZE)) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (!plan_ready) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rec_d = rd_data;
        if (!plan_ready) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!plan_ready) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          op_d   = f_op;
          cidx_d = idx_q;
          if (f_op == 2'd0) begin
            kind_d = 1'b0;
            src0_d = '0;
            src1_d = '0;
            m_d    = f_a_w0;
            k_d    = f_a_l0;
            n_d    = f_b_l0;
          end else begin
            kind_d = 1'b1;
            src0_d = f_to_n1;
            src1_d = f_to_n2;
            m_d    = f_o_w0;
            k_d    = '0;
            n_d    = f_o_l0;
          end
          if (rec_bad) begin
            err_d = 1'b1;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // An abort seen while stalled is remembered so the offered command
        // still completes its handshake before the walk ends.
        if (!plan_ready) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
        end
        if (cmd_ready) begin
          count_d = count_q + 16'd1;
          if (abort_q || !plan_ready || (idx_q == '0)) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q - 16'd1;
            state_d = S_READ;
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en     = (state_q == S_READ);
  assign rd_addr   = rd_en ? idx_q : '0;
  assign cmd_valid = (state_q == S_ISSUE);
  assign done      = (state_q == S_FIN);
  assign busy      = busy_q;
  assign err       = err_q;
  assign cmd_count = count_q;
  assign cmd_kind  = kind_q;
  assign cmd_op    = op_q;
  assign cmd_idx   = cidx_q;
  assign cmd_src0  = src0_q;
  assign cmd_src1  = src1_q;
  assign cmd_m     = m_q;
  assign cmd_k     = k_q;
  assign cmd_n     = n_q;

endmodule

// File: tb/tb_sys_split_plan_reader.sv
// Directed bench for sys_split_plan_reader: small plan tables, hand-computed
// command sequences, stall/abort/range/reset cases and the optional check build.
module tb_sys_split_plan_reader;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         plan_ready = 1'b0;
  logic [15:0]  plan_last = '0;
  logic         rd_en;
  logic [15:0]  rd_addr;
  logic [258:0] rd_data = '0;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic         cmd_kind;
  logic [1:0]   cmd_op;
  logic [15:0]  cmd_idx, cmd_src0, cmd_src1, cmd_m, cmd_k, cmd_n;
  logic         busy, done, err;
  logic [15:0]  cmd_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

`ifdef SPLIT_READER_CHECK_EN
  localparam logic EXP_CHECK_ERR = 1'b1;
`else
  localparam logic EXP_CHECK_ERR = 1'b0;
`endif

  logic [258:0] mem [0:3];

  sys_split_plan_reader #(
    .ARRAY_MAX_W   (4),
    .ARRAY_MAX_L   (4),
    .ARRAY_MAX_A_L (4),
    .OUT_SIZE      (100)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .plan_ready (plan_ready),
    .plan_last  (plan_last),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_op     (cmd_op),
    .cmd_idx    (cmd_idx),
    .cmd_src0   (cmd_src0),
    .cmd_src1   (cmd_src1),
    .cmd_m      (cmd_m),
    .cmd_k      (cmd_k),
    .cmd_n      (cmd_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cmd_count  (cmd_count)
  );

  always #5 clk = ~clk;

  // Table memory: data appears exactly one cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[1:0]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [258:0] mkrec(input logic [15:0] aw0, al0, bw0, bl0,
                                         input logic [15:0] ow0, ol0, n1, n2,
                                         input logic [1:0] op);
    logic [258:0] r;
    r = '0;
    r[258:243] = 16'hBEEF;
    r[242:227] = aw0;
    r[226:211] = al0;
    r[210:195] = 16'h0007;
    r[178:163] = bw0;
    r[162:147] = bl0;
    r[114:99]  = ow0;
    r[98:83]   = ol0;
    r[50:35]   = n1;
    r[34:19]   = n2;
    r[18:2]    = 17'h1FFFF;
    r[1:0]     = op;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rd_en"},     32'(rd_en),     32'd0);
    check({tag, ".rd_addr"},   32'(rd_addr),   32'd0);
    check({tag, ".cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, ".cmd_kind"},  32'(cmd_kind),  32'd0);
    check({tag, ".cmd_op"},    32'(cmd_op),    32'd0);
    check({tag, ".cmd_idx"},   32'(cmd_idx),   32'd0);
    check({tag, ".cmd_src"},   32'({cmd_src0, cmd_src1}), 32'd0);
    check({tag, ".cmd_mkn"},   32'(cmd_m | cmd_k | cmd_n), 32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".done"},      32'(done),      32'd0);
    check({tag, ".err"},       32'(err),       32'd0);
    check({tag, ".cmd_count"}, 32'(cmd_count), 32'd0);
  endtask

  task automatic check_fields(input string tag, input logic kind, input logic [1:0] op,
                              input logic [15:0] idx, s0, s1, m, k, n);
    check({tag, ".kind"}, 32'(cmd_kind), 32'(kind));
    check({tag, ".op"},   32'(cmd_op),   32'(op));
    check({tag, ".idx"},  32'(cmd_idx),  32'(idx));
    check({tag, ".src0"}, 32'(cmd_src0), 32'(s0));
    check({tag, ".src1"}, 32'(cmd_src1), 32'(s1));
    check({tag, ".m"},    32'(cmd_m),    32'(m));
    check({tag, ".k"},    32'(cmd_k),    32'(k));
    check({tag, ".n"},    32'(cmd_n),    32'(n));
  endtask

  // Waits (bounded) for a command, checks it, completes the handshake.
  // With stall=1, cmd_ready is held low for one cycle first so the fields
  // must stay stable, then pulsed high for exactly one cycle.
  task automatic expect_cmd(input string tag, input bit stall, input logic kind,
                            input logic [1:0] op, input logic [15:0] idx, s0, s1, m, k, n,
                            output int unsigned waited);
    waited = 0;
    while (cmd_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    check({tag, ".valid"}, 32'(cmd_valid), 32'd1);
    check_fields(tag, kind, op, idx, s0, s1, m, k, n);
    if (stall) begin
      tick();
      check({tag, ".held_valid"}, 32'(cmd_valid), 32'd1);
      check_fields({tag, ".held"}, kind, op, idx, s0, s1, m, k, n);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
    end else begin
      tick();
    end
    check({tag, ".gone"}, 32'(cmd_valid), 32'd0);
  endtask

  task automatic load_table_a();
    mem[0] = mkrec(16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd4, 16'd1, 16'd2, 2'd1);
    mem[1] = mkrec(16'd4, 16'd2, 16'd2, 16'd4, 16'd0, 16'd0, 16'd9, 16'd0, 2'd0);
    mem[2] = mkrec(16'd1, 16'd2, 16'd2, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0);
    mem[3] = '0;
  endtask

  initial begin
    int unsigned w;
    int unsigned t0;

    load_table_a();

    // Reset state
    tick();
    tick();
    check_zero("RST");
    reset_n = 1'b1;
    plan_ready = 1'b1;
    tick();
    check_zero("IDLE");

    // Table A, cmd_ready held high
    plan_last = 16'd2;
    cmd_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    check("A.busy", 32'(busy), 32'd1);
    expect_cmd("A.i2", 1'b0, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0, 16'd1, 16'd2, 16'd4, w);
    check("A.first_latency", w, 32'd3);
    expect_cmd("A.i1", 1'b0, 1'b0, 2'd0, 16'd1, 16'd0, 16'd0, 16'd4, 16'd2, 16'd4, w);
    check("A.rec_latency", w, 32'd3);
    expect_cmd("A.i0", 1'b0, 1'b1, 2'd1, 16'd0, 16'd1, 16'd2, 16'd5, 16'd0, 16'd4, w);
    check("A.done", 32'(done), 32'd1);
    check("A.done_cycle", cyc - t0, 32'd12);
    check("A.count", 32'(cmd_count), 32'd3);
    check("A.err", 32'(err), 32'd0);
    tick();
    check("A.done_pulse", 32'(done), 32'd0);
    check("A.busy_end", 32'(busy), 32'd0);

    // Reset while a command is stalled in ISSUE
    cmd_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (cmd_valid !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check("R.valid_before", 32'(cmd_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_zero("R.async");
    tick();
    reset_n = 1'b1;
    check_zero("R.after");

    // Table A again, cmd_ready alternating: same sequence, nothing lost or duplicated
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_cmd("B.i2", 1'b1, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0, 16'd1, 16'd2, 16'd4, w);
    expect_cmd("B.i1", 1'b1, 1'b0, 2'd0, 16'd1, 16'd0, 16'd0, 16'd4, 16'd2, 16'd4, w);
    expect_cmd("B.i0", 1'b1, 1'b1, 2'd1, 16'd0, 16'd1, 16'd2, 16'd5, 16'd0, 16'd4, w);
    check("B.done", 32'(done), 32'd1);
    check("B.count", 32'(cmd_count), 32'd3);
    tick();

    // plan_ready drops while the first command is stalled: abort after its handshake
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (cmd_valid !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check("AB.valid", 32'(cmd_valid), 32'd1);
    plan_ready = 1'b0;
    tick();
    check("AB.err", 32'(err), 32'd1);
    check("AB.held", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    plan_ready = 1'b1;
    check("AB.done", 32'(done), 32'd1);
    check("AB.count", 32'(cmd_count), 32'd1);
    check("AB.no_more", 32'(cmd_valid), 32'd0);
    tick();
    check("AB.idle", 32'(busy), 32'd0);
    check("AB.sticky", 32'(err), 32'd1);

    // start without plan_ready is ignored
    plan_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("NR.busy", 32'(busy), 32'd0);
    check("NR.rd_en", 32'(rd_en), 32'd0);
    plan_ready = 1'b1;

    // plan_last out of range
    plan_last = 16'd100;
    cmd_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("OR.done", 32'(done), 32'd1);
    check("OR.err", 32'(err), 32'd1);
    check("OR.valid", 32'(cmd_valid), 32'd0);
    check("OR.rd_en", 32'(rd_en), 32'd0);
    tick();
    check("OR.done_pulse", 32'(done), 32'd0);
    check("OR.valid2", 32'(cmd_valid), 32'd0);
    check("OR.count", 32'(cmd_count), 32'd0);

    // plan_last = 0, single leaf; err cleared by the new start
    mem[0] = mkrec(16'd2, 16'd2, 16'd2, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0);
    plan_last = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("L.err_clear", 32'(err), 32'd0);
    expect_cmd("L.i0", 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd2, 16'd2, w);
    check("L.done", 32'(done), 32'd1);
    check("L.count", 32'(cmd_count), 32'd1);
    check("L.err", 32'(err), 32'd0);
    tick();

    // Oversized leaf: issued either way, err only in the checking build
    mem[0] = mkrec(16'd5, 16'd2, 16'd2, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 2'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_cmd("C.i0", 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd2, 16'd4, w);
    check("C.done", 32'(done), 32'd1);
    check("C.err", 32'(err), 32'(EXP_CHECK_ERR));
    check("C.count", 32'(cmd_count), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sys_split_plan_reader.md
Name: sys_split_plan_reader

Overview:
- Consumer end of the split-plan interface. The split generator fills a table of split_type records, indices 0..last, and raises ready.
- This block walks that table in reverse index order, last down to 0, so children are visited before the parents that merge them.
- Each leaf record becomes a compute command; each merge record becomes a combine command. Commands go out over a valid/ready handshake to the array sequencer.
- Sits between sys_array_split and the tile scheduler.

Parameters:
- ARRAY_MAX_W, 4, max array width; leaf A_W_0 must be ≤ this.
- ARRAY_MAX_L, 4, max array length; leaf B_L_0 must be ≤ this.
- ARRAY_MAX_A_L, 4, max shared dimension; leaf A_L_0 must be ≤ this.
- OUT_SIZE, 100, table depth; plan_last must be < OUT_SIZE.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begin a walk. Only accepted in IDLE with plan_ready=1.
- plan_ready  in  1  generator's ready; the table is stable while high.
- plan_last  in  16  index of the last valid record.
- rd_en  out  1  table read strobe.
- rd_addr  out  16  table index being read.
- rd_data  in  259  packed split_type record. Valid exactly 1 cycle after rd_en.
  - Layout, MSB first: n[258:243], A_W_0, A_L_0, A_W_1, A_L_1, B_W_0, B_L_0, B_W_1, B_L_1, O_W_0, O_L_0, O_W_1, O_L_1 (16 bits each), to_n1[50:35], to_n2[34:19], parent[18:2] (signed), operation[1:0].
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  sequencer accepts the command.
- cmd_kind  out  1  0 = compute, 1 = combine.
- cmd_op  out  2  operation field: 0 none, 1 sum, 2 hor, 3 vert.
- cmd_idx  out  16  record index.
- cmd_src0, cmd_src1  out  16 each  to_n1 / to_n2. Zero for compute commands.
- cmd_m, cmd_k, cmd_n  out  16 each  leaf A_W_0, A_L_0, B_L_0. Taken from O_W_0/0/O_L_0 for combine commands.
- busy  out  1  walk in progress.
- done  out  1  1-cycle pulse at the end of a walk.
- err  out  1  sticky error flag; cleared on the next accepted start.
- cmd_count  out  16  commands accepted in the current walk.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs 0: rd_en, rd_addr, cmd_*, busy, done, err, cmd_count. Any in-flight command is dropped without handshake.
- IDLE:
  - start & plan_ready: idx←plan_last, busy←1, cmd_count←0, err←0, go to READ.
  - start & !plan_ready: ignored, stays IDLE.
  - start while busy: ignored.
- READ: rd_en=1 for one cycle, rd_addr=idx. Go to WAIT.
- WAIT: register rd_data into a record holding register. Go to DECODE.
- DECODE:
  - operation==0 → cmd_kind=0, cmd_m/k/n from leaf fields.
  - otherwise → cmd_kind=1, src0/src1 from to_n1/to_n2.
  - cmd_idx=idx. Go to ISSUE.
- ISSUE:
  - cmd_valid=1. All cmd_* fields are held stable until cmd_ready.
  - On cmd_valid & cmd_ready: cmd_count++. If idx==0 go to FIN; otherwise idx−1 and go to READ.
  - cmd_valid must never drop without a handshake.
- FIN: done=1 for one cycle, busy←0, go to IDLE.
- Cost: minimum 4 cycles per record (READ, WAIT, DECODE, ISSUE with cmd_ready=1). Latency from start to first cmd_valid is 3 cycles.
- plan_ready falling mid-walk: walk is aborted. err←1, no further commands, go to FIN (done still pulses).
- plan_last ≥ OUT_SIZE at start: err←1, zero commands issued, go to FIN.
- plan_last==0: exactly one record is read and issued.
- idx decrement never wraps; the idx==0 check precedes the decrement.
- Width rules: all dimension fields are unsigned 16-bit; parent is signed 17-bit and is not used for sequencing.

Optional Feature:
- Macro: SPLIT_READER_CHECK_EN.
- With the macro defined, DECODE additionally checks:
  - Leaf records: B_W_0==A_L_0, A_W_0≤ARRAY_MAX_W, A_L_0≤ARRAY_MAX_A_L, B_L_0≤ARRAY_MAX_L, and no dimension is 0.
  - Combine records: to_n1 and to_n2 are both ≤ plan_last and both > idx.
  - On failure: err←1, the command is still issued (walk continues).
- Without the macro: no checks are performed; err is set only by the abort/range conditions above.

Test Plan:
- Reset mid-ISSUE (cmd_valid=1, cmd_ready=0), reset_n low 1 cycle → all outputs 0 that cycle, IDLE; a later start walks normally.
- Table {0: sum, to_n1=1, to_n2=2; 1: leaf 4×2·2×4; 2: leaf 1×2·2×4}, plan_last=2, cmd_ready=1 → commands in order idx2 compute (1,2,4), idx1 compute (4,2,4), idx0 combine op=1 src 1/2. cmd_count=3; done 12 cycles after start+3.
- Same table, cmd_ready toggling 0/1 every cycle → identical command sequence with fields held stable while stalled; no command lost or duplicated.
- plan_last=0, single leaf 2×2·2×2 → exactly one compute command, done pulse, err=0.
- plan_last=100 with OUT_SIZE=100 → err=1, done pulse, cmd_valid never asserted.
- SPLIT_READER_CHECK_EN defined, leaf A_W_0=5 (> 4) → err=1, command still issued with cmd_m=5; with the macro undefined → err=0.
